mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for one shared memory port: IDLE/START/WAIT transaction FSM.
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin instead of fixed priority to requester 0.
module mem_port_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic              mem_ready,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic              err,
    output logic              mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    state_t     state;
    state_t     next_state;
    logic       take;
    logic       pick;
    logic       finish;
    logic       abort;
    logic [7:0] wait_cnt;

`ifdef ARB_ROUND_ROBIN_EN
    logic       last_owner;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        take       = 1'b0;
        pick       = 1'b0;
        finish     = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (req0 | req1) begin
                    take       = 1'b1;
                    next_state = START;
`ifdef ARB_ROUND_ROBIN_EN
                    pick = (req0 & req1) ? ~last_owner : req1;
`else
                    pick = ~req0;
`endif
                end
            end
            START: begin
                next_state = WAIT;
            end
            WAIT: begin
                if (mem_ready) begin
                    finish     = 1'b1;
                    next_state = IDLE;
                end else if (wait_cnt + 8'd1 == WAIT_LIMIT) begin
                    abort      = 1'b1;
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Grants are registered so they stay up through the done cycle and are
    // cleared in the following IDLE cycle, or handed straight to a new owner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            err      <= 1'b0;
            mem_sel  <= 1'b0;
            mem_addr <= '0;
            wait_cnt <= '0;
        end else begin
            done0 <= (finish | abort) & ~mem_sel;
            done1 <= (finish | abort) & mem_sel;
            err   <= abort;
            if (take) begin
                gnt0     <= ~pick;
                gnt1     <= pick;
                mem_sel  <= pick;
                mem_addr <= pick ? addr1 : addr0;
            end else if (state == IDLE) begin
                gnt0 <= 1'b0;
                gnt1 <= 1'b0;
            end
            if (state == START) begin
                wait_cnt <= '0;
            end else if (state == WAIT && !mem_ready) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner <= 1'b1;
        end else if (take) begin
            last_owner <= pick;
        end
    end
`endif

    assign mem_en = (state == START);
    assign busy   = (state != IDLE);

endmodule
